ym_bus_sequencer: RTL
=====================

# ym_bus_sequencer

Sequences register accesses to the two TurboSound YM2149 chips on the shared BDIR/BC1/DA bus. It arbitrates between two requesters, for example the CPU port-capture path and an autonomous music/DMA player, and emits the YM2149 protocol with programmable phase widths. It also drives the chip-select line and returns read data. The block sits between the port-decode logic and the YM pins, replacing direct CPU-strobe decoding when a second bus master is present.

## Interface
- PHASE_CYCLES, 4: clk cycles per active bus phase (latch or data); legal range ≥1.
- GAP_CYCLES, 2: clk cycles of inactive bus after each active phase; legal range ≥1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request; fields held stable until accepted.
- req_ready  out  2  one-cycle accept pulse per requester; at most one bit set.
- req_write  in  2  per-requester: 1 = write, 0 = read.
- req_chip  in  2  per-requester chip select: 0 = chip 0, 1 = chip 1.
- req_addr  in  2x4  per-requester YM register index 0–15.
- req_wdata  in  2x8  per-requester write data.
- rsp_valid  out  2  one-cycle pulse to the requester whose read completed.
- rsp_rdata  out  8  read data; valid only while rsp_valid is nonzero.
- bdir, bc1  out  1 each  YM bus control.
- da_out  out  8  bus drive value.
- da_oe  out  1  bus output enable.
- da_in  in  8  bus sample.
- ym_sel  out  1  selected chip; the chip-0 enable is ~ym_sel and the chip-1 enable is ym_sel.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → ADDR → GAP1 → DATA → GAP2 → IDLE.
- IDLE:
  - Bus is inactive (bdir=0, bc1=0, da_oe=0).
  - If any req_valid bit is set, the arbiter grants one requester and pulses its req_ready.
  - The granted fields are captured into internal registers.
  - ym_sel is updated from the captured chip, and the FSM moves to ADDR.
- ADDR (PHASE_CYCLES cycles): bdir=1, bc1=1, da_oe=1, da_out={4'b0, addr}.
- GAP1 (GAP_CYCLES cycles): bdir=0, bc1=0, da_oe=0.
- DATA (PHASE_CYCLES cycles):
  - Write: bdir=1, bc1=0, da_oe=1, da_out=wdata.
  - Read: bdir=0, bc1=1, da_oe=0. da_in is registered on the last DATA cycle.
- GAP2 (GAP_CYCLES cycles):
  - Bus is inactive.
  - For a read, rsp_valid[owner] pulses on the first GAP2 cycle with the registered data.
  - A write produces no response.
- Arbitration (round-robin):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- ym_sel changes only in the IDLE grant cycle and is stable for the whole transaction. It holds its value between transactions.
- da_out holds its last value when da_oe=0.
- A single shared down-counter times every phase. It loads PHASE_CYCLES-1 or GAP_CYCLES-1 on state entry, and the state advances when the counter reaches 0.

## Timing
- Reset values: state=IDLE, bdir=0, bc1=0, da_oe=0, da_out=0, ym_sel=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, last-grant pointer=1.
- Grant cycle is cycle 0 (req_ready high). ADDR spans cycles 1..P, GAP1 spans P+1..P+G, DATA spans P+G+1..2P+G, GAP2 spans 2P+G+1..2P+2G. Here P=PHASE_CYCLES and G=GAP_CYCLES.
- The FSM is back in IDLE at cycle 2P+2G+1. The earliest next grant is that same cycle, so the transaction period is 2P+2G+1 cycles.
- Read response latency: rsp_valid rises at cycle 2P+G+1 after req_ready.
- bdir and bc1 never change in the same cycle directly between two active codes; every transition passes through 00.
- req_valid deasserted before acceptance: the request is withdrawn and not granted.
- Requests arriving while busy are held off (req_ready stays low) until IDLE.
- Reset asserted mid-transaction: all outputs go to their reset values asynchronously. No rsp_valid is issued, and the in-flight access is dropped.
- P=1, G=1 is legal: each phase lasts exactly one cycle.

## Structure
- Shared package ym_bus_pkg holds:
  - the state enum;
  - bus-mode constants as {bdir,bc1}: BUS_IDLE=00, BUS_READ=01, BUS_WRITE=10, BUS_LATCH=11;
  - the request field widths (address 4, data 8).
- Sub-module rr_arbiter2: two-input round-robin arbiter with a grant-enable input and a last-grant pointer.

## Test plan
- Reset, then req0 writes chip 0, addr 7, data 0x3E (P=4, G=2):
  - {bdir,bc1}=11 with da_out=0x07 for cycles 1–4;
  - 00 for cycles 5–6;
  - 10 with da_out=0x3E for cycles 7–10;
  - 00 for cycles 11–12;
  - busy falls at cycle 13; no rsp_valid.
- req1 reads chip 1, addr 14, with the bench driving da_in=0xA5 during DATA:
  - ym_sel=1 from cycle 1;
  - DATA shows bc1=1, bdir=0, da_oe=0;
  - rsp_valid=2'b10 with rsp_rdata=0xA5 at cycle 11.
- Both requesters valid continuously:
  - grants alternate 0,1,0,1;
  - each grant is separated by 13 cycles;
  - req_ready is never two bits at once.
- Reset pulsed low during DATA of a write: outputs return to reset values immediately, and after release the FSM is in IDLE with no response.
- P=1, G=1 back-to-back writes from req0: transaction period is 5 cycles, and {bdir,bc1} sequence is 11,00,10,00,00(IDLE).
- Monitor check across all tests: a bus-mode change never goes directly 11↔10, and ym_sel never changes while busy=1.

Source files
------------

// File: rtl/ym_bus_sequencer_pkg.sv
// ym_bus_pkg: shared types and constants for the YM2149 bus sequencer.
//   state_e  - sequencer FSM states
//   BUS_*    - {bdir,bc1} bus-mode codes
//   req_t    - captured request fields
package ym_bus_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2
  } state_e;

  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_LATCH = 2'b11;

  typedef struct packed {
    logic              write;
    logic              chip;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/ym_bus_sequencer_if.sv
// ym_bus_sequencer_if: requester handshake plus YM2149 pin bundle.
//   slave  - sequencer side (takes requests, drives the YM pins)
//   master - environment side (issues requests, models the YM pins)
interface ym_bus_sequencer_if;
  import ym_bus_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_write;
  logic [1:0]             req_chip;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   bdir;
  logic                   bc1;
  logic [DATA_W-1:0]      da_out;
  logic                   da_oe;
  logic [DATA_W-1:0]      da_in;
  logic                   ym_sel;
  logic                   busy;

  modport slave (
    input  req_valid, req_write, req_chip, req_addr, req_wdata, da_in,
    output req_ready, rsp_valid, rsp_rdata, bdir, bc1, da_out, da_oe, ym_sel, busy
  );

  modport master (
    output req_valid, req_write, req_chip, req_addr, req_wdata, da_in,
    input  req_ready, rsp_valid, rsp_rdata, bdir, bc1, da_out, da_oe, ym_sel, busy
  );
endinterface

// File: rtl/ym_bus_sequencer_arb.sv
// rr_arbiter2: two-input round-robin arbiter.
//   clk, reset - clock, async active-low reset
//   en         - grant allowed this cycle
//   req        - request bits
//   gnt        - one-hot grant (combinational); pointer advances on grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // tie: whoever was not granted last wins
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    last_d = (|gnt) ? gnt[1] : last_q;
  end

  // pointer resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/ym_bus_sequencer.sv
// ym_bus_sequencer: arbitrates two requesters onto the TurboSound YM2149
// BDIR/BC1/DA bus, emitting latch/data phases of programmable width.
//   clk, reset   - clock, async active-low reset
//   bus (slave)  - request/response handshake and YM pins
//   PHASE_CYCLES - cycles per active phase (>=1)
//   GAP_CYCLES   - idle cycles after each active phase (>=1)
module ym_bus_sequencer
  import ym_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic              clk,
  input logic              reset,
  ym_bus_sequencer_if.slave bus
);
  localparam logic [15:0] P_LD = 16'(PHASE_CYCLES - 1);
  localparam logic [15:0] G_LD = 16'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  req_t              txn_q, txn_d;
  logic              owner_q, owner_d;
  logic              ym_sel_q, ym_sel_d;
  logic [DATA_W-1:0] da_out_q, da_out_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;
  logic [1:0]        bus_mode;
  logic              da_oe;
  logic [1:0]        rsp_valid;
  logic              cnt_zero;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == S_IDLE),
    .req   (bus.req_valid),
    .gnt   (gnt)
  );

  assign cnt_zero = (cnt_q == 16'd0);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      txn_q    <= '0;
      owner_q  <= 1'b0;
      ym_sel_q <= 1'b0;
      da_out_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      txn_q    <= txn_d;
      owner_q  <= owner_d;
      ym_sel_q <= ym_sel_d;
      da_out_q <= da_out_d;
      rdata_q  <= rdata_d;
    end
  end

  // next state; one shared down-counter times every phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_zero ? cnt_q : cnt_q - 16'd1;
    txn_d    = txn_q;
    owner_d  = owner_q;
    ym_sel_d = ym_sel_q;
    da_out_d = da_out_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (|gnt) begin
        state_d     = S_ADDR;
        cnt_d       = P_LD;
        owner_d     = gnt[1];
        txn_d.write = bus.req_write[gnt[1]];
        txn_d.chip  = bus.req_chip[gnt[1]];
        txn_d.addr  = bus.req_addr[gnt[1]];
        txn_d.wdata = bus.req_wdata[gnt[1]];
        ym_sel_d    = bus.req_chip[gnt[1]];
        da_out_d    = {4'b0, bus.req_addr[gnt[1]]};
      end
      S_ADDR: if (cnt_zero) begin
        state_d = S_GAP1;
        cnt_d   = G_LD;
      end
      S_GAP1: if (cnt_zero) begin
        state_d = S_DATA;
        cnt_d   = P_LD;
        if (txn_q.write) da_out_d = txn_q.wdata;
      end
      S_DATA: if (cnt_zero) begin
        state_d = S_GAP2;
        cnt_d   = G_LD;
        // sample the chip on the last read-phase cycle
        if (!txn_q.write) rdata_d = bus.da_in;
      end
      S_GAP2: if (cnt_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs; every active code is entered from and left to BUS_IDLE
  always_comb begin
    bus_mode  = BUS_IDLE;
    da_oe     = 1'b0;
    rsp_valid = 2'b00;
    case (state_q)
      S_ADDR: begin
        bus_mode = BUS_LATCH;
        da_oe    = 1'b1;
      end
      S_DATA: begin
        bus_mode = txn_q.write ? BUS_WRITE : BUS_READ;
        da_oe    = txn_q.write;
      end
      S_GAP2: if (!txn_q.write && cnt_q == G_LD) rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.bdir      = bus_mode[1];
  assign bus.bc1       = bus_mode[0];
  assign bus.da_out    = da_out_q;
  assign bus.da_oe     = da_oe;
  assign bus.ym_sel    = ym_sel_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule
